ram3840_arbiter: RTL and testbench
==================================

# ram3840_arbiter

Two-port arbiter that shares the single-ported 3840-word data RAM between the HACK CPU (port A) and a bulk loader/DMA master (port B, e.g. the boot loader that copies program data into RAM). Each cycle it grants at most one requester, drives the RAM address/data/load lines, and returns registered read data with a valid pulse one cycle later. It also range-checks addresses, and bounds burst locking so the CPU cannot be starved.

## Interface
Parameters:
- DEPTH, 3840, number of implemented RAM words; addresses >= DEPTH are out of range.
- BURST_MAX, 16, maximum consecutive locked B grants while A is waiting (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; a_we, a_addr, a_wdata held stable until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  16  word address.
- a_wdata  in  16  write data.
- a_gnt  out  1  combinational; request accepted this cycle.
- a_rvalid  out  1  registered; a_rdata valid (pulse, read grants only).
- a_rdata  out  16  registered read data; holds until next a_rvalid.
- a_err  out  1  registered; pulse one cycle after an out-of-range grant.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: same as port A, for port B.
- b_lock  in  1  B requests back-to-back priority (burst).
- ram_address  out  16  to RAM address.
- ram_in  out  16  to RAM write data.
- ram_load  out  1  RAM write enable.
- ram_out  in  16  RAM read data; asynchronous read, valid in the same cycle as ram_address.

## Operation
- A request is one transaction. Grant cycle t, one grant per cycle, never both ports.
- Arbitration in cycle t, by priority:
  1. Only one req: that port wins.
  2. Both req, lock active: B wins. Lock is active when b_lock=1 and last grant was B and burst_cnt < BURST_MAX.
  3. Both req, otherwise: round-robin. The port not granted last wins.
- State: last (0=A, 1=B), burst_cnt[7:0].
- burst_cnt increments on each B grant while a_req=1. It clears on any A grant, or on a B grant while a_req=0.
- Starvation bound: with a_req held, A is granted within BURST_MAX+1 cycles.
- RAM drive:
  - ram_address = winner addr; ram_in = winner wdata.
  - ram_load = gnt & we & (addr < DEPTH).
  - With no grant: ram_load=0, ram_address/ram_in = port A values.
- Read grant: at the t edge, ram_out is captured into the winner's rdata and rvalid pulses in t+1. If out of range, rdata captures 0 instead of ram_out.
- Out-of-range grant (read or write): err pulses in t+1. The write is dropped. The RAM is never written at addr >= DEPTH, including aliases of address[11:0].
- Other port's rdata is untouched.
- Read-after-write from either port sees the new data in the following cycle.

## Timing
- Grant latency 0: a_gnt/b_gnt are combinational from req, lock and state.
- Read latency 1: rvalid and rdata are valid the cycle after the grant.
- Throughput: one access per cycle, sustained, alternating under contention.
- Reset (rst_n=0, asynchronous): the following are all cleared immediately:
  - a_rvalid, b_rvalid, a_err, b_err, a_rdata, b_rdata, burst_cnt = 0.
  - last = B, so A wins the first contested cycle.
- Grants and ram_load are forced to 0 while rst_n=0.
- Reset mid-read: pending rvalid/err are lost and never issued.
- Deassertion is synchronised externally. The first grant can occur in the first cycle with rst_n=1.
- Requester dropping req without gnt: legal; no side effects.

## Test plan
- Reset: assert rst_n=0 mid-cycle with b_req=1 -> all outputs 0 immediately; after release, both req -> a_gnt first.
- Single port A: write 0x1234 to 100, read 100 next cycle -> ram_load=1 for one cycle; a_rvalid=1 with a_rdata=0x1234 one cycle after read grant.
- Contention, no lock: both req continuously for 6 cycles -> grants A,B,A,B,A,B; rdata routed only to the granted port.
- Lock bound: BURST_MAX=4, b_lock=1, both req held -> B,B,B,B (after an initial A), then A, then B resumes; A never waits more than 5 cycles.
- Out of range: A write 0xBEEF to 3840, then read 3840 and read 3840-3840+256 alias (256) -> no ram_load on the write; a_err pulses after each out-of-range grant; read of 3840 gives a_rdata=0; word 256 unchanged.
- Reset mid-read: grant read, assert rst_n=0 before next edge -> no a_rvalid ever issued for that read.

Source files
------------

// File: rtl/ram3840_arbiter.sv
// Two-port arbiter for the shared single-ported data RAM (CPU on A, loader/DMA on B).
// Grant is combinational, read data and error are returned one cycle later; a losing requester simply holds its request.
module ram3840_arbiter #(
  parameter int DEPTH     = 3840,
  parameter int BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic        b_err,
  output logic [15:0] ram_address,
  output logic [15:0] ram_in,
  output logic        ram_load,
  input  logic [15:0] ram_out
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [7:0]  BMAX_L  = 8'(BURST_MAX);

  logic        last_q, last_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic [15:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic        a_inr, b_inr, lock_act, b_win;

  always_comb begin
    a_inr    = {1'b0, a_addr} < DEPTH_L;
    b_inr    = {1'b0, b_addr} < DEPTH_L;
    lock_act = b_lock & last_q & (burst_cnt_q < BMAX_L);
    // Under contention B wins on an active lock or when A was granted last.
    b_win    = b_req & (~a_req | lock_act | ~last_q);
    a_gnt    = rst_n & a_req & ~b_win;
    b_gnt    = rst_n & b_win;

    ram_address = b_gnt ? b_addr  : a_addr;
    ram_in      = b_gnt ? b_wdata : a_wdata;
    // Out-of-range writes are dropped so 12-bit address aliases are never hit.
    ram_load    = (a_gnt & a_we & a_inr) | (b_gnt & b_we & b_inr);

    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (a_gnt) begin
      last_d      = 1'b0;
      burst_cnt_d = '0;
    end else if (b_gnt) begin
      last_d = 1'b1;
      if (!a_req)                 burst_cnt_d = '0;
      else if (burst_cnt_q != '1) burst_cnt_d = burst_cnt_q + 8'd1;
    end

    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
    a_err_d    = a_gnt & ~a_inr;
    b_err_d    = b_gnt & ~b_inr;
    a_rdata_d  = a_rvalid_d ? (a_inr ? ram_out : 16'h0000) : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? (b_inr ? ram_out : 16'h0000) : b_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram3840_arbiter.sv
// Scoreboard bench for ram3840_arbiter with a behavioural 4K-word RAM behind it.
module tb_ram3840_arbiter;

  typedef struct packed {
    logic        rv;
    logic        err;
    logic [15:0] dat;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_lock, b_gnt, b_rvalid, b_err;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic [15:0] ram_address, ram_in, ram_out;
  logic        ram_load;

  logic [15:0] mem [4096];
  bit          wr  [4096];

  logic [1:0]  gq [$];
  resp_t       aq [$];
  resp_t       bq [$];
  logic [15:0] a_hold, b_hold;
  int          n_vec = 0;
  int          n_bad = 0;

  ram3840_arbiter #(.DEPTH(3840), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  assign ram_out = wr[ram_address[11:0]] ? mem[ram_address[11:0]]
                                         : init_val({4'h0, ram_address[11:0]});

  always @(posedge clk) begin
    if (ram_load) begin
      mem[ram_address[11:0]] <= ram_in;
      wr[ram_address[11:0]]  <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ar, input logic awe, input logic [15:0] aad, input logic [15:0] awd,
                        input logic br, input logic bwe, input logic [15:0] bad, input logic [15:0] bwd,
                        input logic bl);
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd; b_lock = bl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic resp_t mk(input logic rv, input logic err, input logic [15:0] dat);
    resp_t r;
    r.rv = rv; r.err = err; r.dat = dat;
    return r;
  endfunction

  // Monitor: pops expected grants/responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold = 16'h0000;
      b_hold = 16'h0000;
    end else begin
      if (a_gnt || b_gnt) begin
        if (gq.size() == 0) chk("spurious_grant", 32'({a_gnt, b_gnt}), 32'd0);
        else chk("grant", 32'({a_gnt, b_gnt}), 32'(gq.pop_front()));
      end
      if (a_rvalid || a_err) begin
        if (aq.size() == 0) chk("a_spurious_resp", 32'({a_rvalid, a_err}), 32'd0);
        else begin
          resp_t e;
          e = aq.pop_front();
          chk("a_rvalid", 32'(a_rvalid), 32'(e.rv));
          chk("a_err", 32'(a_err), 32'(e.err));
          if (e.rv) a_hold = e.dat;
          chk("a_rdata", 32'(a_rdata), 32'(a_hold));
        end
      end else chk("a_rdata_hold", 32'(a_rdata), 32'(a_hold));
      if (b_rvalid || b_err) begin
        if (bq.size() == 0) chk("b_spurious_resp", 32'({b_rvalid, b_err}), 32'd0);
        else begin
          resp_t e;
          e = bq.pop_front();
          chk("b_rvalid", 32'(b_rvalid), 32'(e.rv));
          chk("b_err", 32'(b_err), 32'(e.err));
          if (e.rv) b_hold = e.dat;
          chk("b_rdata", 32'(b_rdata), 32'(b_hold));
        end
      end else chk("b_rdata_hold", 32'(b_rdata), 32'(b_hold));
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"}, 32'({a_gnt, b_gnt}), 32'd0);
    chk({nm, "_load"}, 32'(ram_load), 32'd0);
    chk({nm, "_valid_err"}, 32'({a_rvalid, b_rvalid, a_err, b_err}), 32'd0);
    chk({nm, "_rdata"}, {a_rdata, b_rdata}, 32'd0);
  endtask

  initial begin
    int ia, ib;
    logic [9:0] lock_seq;
    rst_n = 1'b1;
    set_in(0, 0, 16'd0, 16'd0, 0, 0, 16'd0, 16'd0, 0);
    #1;
    rst_n = 1'b0;
    b_req = 1'b1;
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention without lock: A first after reset, then strict alternation.
    ia = 0; ib = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 16'(200 + ia), 16'd0, 1, 0, 16'(300 + ib), 16'd0, 0);
      if (i % 2 == 0) begin
        gq.push_back(2'b10);
        aq.push_back(mk(1, 0, init_val(16'(200 + ia))));
        #1 chk("rr_addr_a", 32'(ram_address), 32'(200 + ia));
        ia++;
      end else begin
        gq.push_back(2'b01);
        bq.push_back(mk(1, 0, init_val(16'(300 + ib))));
        #1 chk("rr_addr_b", 32'(ram_address), 32'(300 + ib));
        ib++;
      end
      step();
    end

    // Single port A: write then read back.
    set_in(1, 1, 16'd100, 16'h1234, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    #1 chk("a_wr_bus", {ram_address, ram_in}, {16'd100, 16'h1234});
    chk("a_wr_load", 32'(ram_load), 32'd1);
    step();
    set_in(1, 0, 16'd100, 16'h0000, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    aq.push_back(mk(1, 0, 16'h1234));
    #1 chk("a_rd_load", 32'(ram_load), 32'd0);
    step();

    // Lock with BURST_MAX=4, A granted last: four B, one A, repeat.
    lock_seq = 10'b1111011110;
    ia = 0; ib = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 16'(500 + ia), 16'd0, 1, 1, 16'(400 + ib), 16'(16'hC000 + ib), 1);
      if (lock_seq[9 - i]) begin
        gq.push_back(2'b01);
        ib++;
      end else begin
        gq.push_back(2'b10);
        aq.push_back(mk(1, 0, init_val(16'(500 + ia))));
        ia++;
      end
      #1 chk("lock_load", 32'(ram_load), 32'(lock_seq[9 - i]));
      step();
    end

    // B reads back its burst writes.
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 16'd0, 16'd0, 1, 0, 16'(400 + k), 16'd0, 0);
      gq.push_back(2'b01);
      bq.push_back(mk(1, 0, 16'(16'hC000 + k)));
      step();
    end

    // Out-of-range accesses, including a 12-bit alias of word 256.
    set_in(1, 1, 16'd3840, 16'hBEEF, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    aq.push_back(mk(0, 1, 16'h0000));
    #1 chk("oor_wr_load", 32'(ram_load), 32'd0);
    step();
    set_in(1, 0, 16'd3840, 16'd0, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    aq.push_back(mk(1, 1, 16'h0000));
    step();
    set_in(1, 0, 16'd256, 16'd0, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    aq.push_back(mk(1, 0, 16'h5B00));
    step();
    set_in(1, 1, 16'd4352, 16'hDEAD, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    aq.push_back(mk(0, 1, 16'h0000));
    #1 chk("alias_wr_load", 32'(ram_load), 32'd0);
    step();
    set_in(1, 0, 16'd256, 16'd0, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    aq.push_back(mk(1, 0, 16'h5B00));
    step();
    set_in(0, 0, 16'd0, 16'd0, 1, 0, 16'hFFFF, 16'd0, 0);
    gq.push_back(2'b01);
    bq.push_back(mk(1, 1, 16'h0000));
    step();

    // Reset between a read grant and its capture edge.
    set_in(1, 0, 16'd100, 16'd0, 0, 0, 16'd0, 16'd0, 0);
    gq.push_back(2'b10);
    @(negedge clk);
    #2;
    b_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1, 0, 16'd100, 16'd0, 1, 0, 16'd256, 16'd0, 0);
    gq.push_back(2'b10);
    aq.push_back(mk(1, 0, 16'h1234));
    step();
    gq.push_back(2'b01);
    bq.push_back(mk(1, 0, 16'h5B00));
    step();
    set_in(0, 0, 16'd0, 16'd0, 0, 0, 16'd0, 16'd0, 0);
    repeat (3) step();

    chk("grants_left", 32'(gq.size()), 32'd0);
    chk("a_resp_left", 32'(aq.size()), 32'd0);
    chk("b_resp_left", 32'(bq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
